trace_match_event_logger: RTL and testbench
===========================================

Name: trace_match_event_logger

Overview:
- Parametrised successor to the single-trigger trace pattern matcher.
- Compares each trace word against pRULES pattern/mask rules and drives a pulse- or toggle-mode trigger.
- Logs every matching cycle as a timestamped event in an on-chip FIFO, so host software reads match history instead of counting trigger edges.
- Sits between the trace decoder (trace_clk domain) and the trace register block; the register block supplies the flat pattern/mask buses and drains the FIFO.

Parameters:
- pDATA_WIDTH, 64: trace word width and pattern/mask width per rule.
- pRULES, 8: number of match rules (1..32).
- pTS_WIDTH, 32: timestamp counter width.
- pFIFO_DEPTH, 16: event FIFO depth (power of 2, >=2).

Ports:
- trace_clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- trace_data  in  pDATA_WIDTH  decoded trace word.
- trace_valid  in  1  trace_data qualifier.
- pattern_flat  in  pRULES*pDATA_WIDTH  rule i occupies bits [i*pDATA_WIDTH +: pDATA_WIDTH].
- mask_flat  in  pRULES*pDATA_WIDTH  1 = bit compared.
- pattern_enable  in  pRULES  per-rule enable.
- trig_enable  in  1  trigger output enable.
- trig_toggle  in  1  0 = pulse mode, 1 = toggle mode.
- capture_en  in  1  FIFO logging enable.
- ts_clear  in  1  single-cycle: zero timestamp, clear overflow, flush FIFO.
- trig_out  out  1  match trigger.
- fifo_rd_en  in  1  pop head entry.
- fifo_dout  out  1+pRULES+pTS_WIDTH  {rollover, hits[pRULES-1:0], timestamp}; show-ahead.
- fifo_empty  out  1
- fifo_full  out  1
- fifo_count  out  $clog2(pFIFO_DEPTH)+1
- fifo_overflow  out  1  sticky: an event was dropped.

Behaviour:
- Reset values:
  - trig_out=0, fifo_empty=1, fifo_full=0, fifo_count=0, fifo_overflow=0.
  - fifo_dout=0; timestamp counter=0; rollover-pending=0.
- Timestamp counter ts:
  - Increments every cycle; wraps from all-ones to 0.
  - ts_clear sets ts=0 next cycle.
  - The wrap sets rollover-pending. rollover-pending clears when an entry is pushed or on ts_clear.
- Stage 1 (cycle N+1): hit[i] registered = trace_valid & pattern_enable[i] & (((trace_data ^ pattern_i) & mask_i) == 0). ts(N) is registered alongside.
  - An all-zero mask with rule enabled matches every valid word.
- Stage 2 (cycle N+2): any_hit = |hit.
  - Pulse mode: trig_out = any_hit & trig_enable. Back-to-back matches hold it high.
  - Toggle mode: trig_out inverts on each any_hit cycle while trig_enable=1.
  - trig_enable=0: pulse output 0; toggle output holds.
  - A mode change takes effect on the next match and does not reset the toggle level.
- Push: on stage-2 any_hit & capture_en, push {rollover-pending, hit, ts(N)}.
  - All simultaneous rule hits go in one entry's hit vector.
  - Rollover bit=1 if one or more wraps occurred since the last push.
- FIFO is synchronous, show-ahead: fifo_dout is valid whenever !fifo_empty, and fifo_rd_en advances it next cycle.
  - Pop when empty: ignored.
  - Push when full without a same-cycle pop: entry dropped, fifo_overflow set, rollover-pending retained.
  - Push when full with a same-cycle pop: accepted, count unchanged.
  - Simultaneous push and pop when empty: push accepted, count becomes 1.
- ts_clear:
  - Flushes the FIFO (count=0, empty=1) and clears fifo_overflow.
  - If a push coincides with ts_clear, ts_clear wins and the entry is discarded.
  - Pipeline hits in flight are still reflected on trig_out.
- Reset mid-operation clears pipeline, FIFO, toggle state and counter in one cycle. No trigger is issued from pre-reset data.
- Latency: trace word to trig_out = 2 cycles; to fifo_empty deassert = 3 cycles.

Decomposition:
- Package trace_match_pkg holds:
  - entry-width function (1+pRULES+pTS_WIDTH);
  - field offset localparams;
  - trigger-mode constants (TRIG_PULSE=0, TRIG_TOGGLE=1).
- One sub-module: trace_event_fifo, a synchronous show-ahead FIFO (width, depth parameters) with count, full, empty and drop-on-full.
- Comparators, timestamp counter and trigger logic stay in the top.

Test Plan:
- Single rule match:
  - Stimulus: rule0 pattern 0x00000000_DEADBEEF, mask 0x00000000_FFFFFFFF, pulse mode. Word 0x12345678_DEADBEEF at ts=100.
  - Response: trig_out high exactly 1 cycle, 2 cycles later. Entry {0, 8'h01, 100}.
- Multi-rule:
  - Stimulus: rules 2 and 5 both match word 0xAA at ts=7.
  - Response: one entry, hits=8'h24. One trig_out pulse.
- Toggle mode:
  - Stimulus: three matches at ts 10, 11, 20.
  - Response: trig_out 0->1->0->1 at ts+2. Toggle held while trig_enable=0.
- Overflow:
  - Stimulus: pFIFO_DEPTH=4, 6 consecutive matches, no reads.
  - Response: count=4, full=1, overflow=1. Entries hold the first 4 timestamps.
  - Follow-up: ts_clear gives empty=1 and overflow=0.
- Rollover:
  - Stimulus: pTS_WIDTH=8. Match at ts=250, then the counter wraps, then a match at ts=3, then a match at ts=9.
  - Response: rollover bits 0, 1, 0.
- Full push+pop and reset:
  - Stimulus: push+pop on a full FIFO.
  - Response: count stays 4 and the head advances.
  - Stimulus: assert reset while 2 matches are in the pipeline.
  - Response: no trig_out, FIFO empty.

Source files
------------

// File: rtl/trace_match_pkg.sv
// trace_match_pkg: shared trigger-mode constants and event-entry layout helpers
package trace_match_pkg;
  localparam logic TRIG_PULSE  = 1'b0;
  localparam logic TRIG_TOGGLE = 1'b1;
  localparam int   TS_LSB      = 0;
  function automatic int entry_width(input int rules, input int ts_width);
    return 1 + rules + ts_width;
  endfunction
  function automatic int hits_lsb(input int ts_width);
    return TS_LSB + ts_width;
  endfunction
  function automatic int rollover_bit(input int rules, input int ts_width);
    return TS_LSB + ts_width + rules;
  endfunction
endpackage

// File: rtl/trace_event_fifo.sv
// trace_event_fifo: synchronous show-ahead FIFO with count, flush and sticky drop-on-full flag
// Ports: trace_clk/reset clocking; flush empties the FIFO and clears overflow;
// wr_en/din push; accepted marks a push that was stored; rd_en pops the head
// presented on dout; empty/full/count status; overflow sticky drop indicator.
module trace_event_fifo #(
  parameter int pWIDTH = 16,
  parameter int pDEPTH = 16
) (
  input  logic                      trace_clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      wr_en,
  input  logic [pWIDTH-1:0]         din,
  output logic                      accepted,
  input  logic                      rd_en,
  output logic [pWIDTH-1:0]         dout,
  output logic                      empty,
  output logic                      full,
  output logic [$clog2(pDEPTH):0]   count,
  output logic                      overflow
);
  localparam int AW = $clog2(pDEPTH);
  logic [pWIDTH-1:0] mem [pDEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic pop;
  assign empty    = count == '0;
  assign full     = count == (AW+1)'(pDEPTH);
  assign pop      = rd_en & ~empty & ~flush;
  // a full FIFO still accepts when the head leaves in the same cycle
  assign accepted = wr_en & ~flush & (~full | rd_en);
  assign dout     = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge trace_clk)
    if (accepted) mem[wr_ptr] <= din;
  always_ff @(posedge trace_clk) begin
    if (reset || flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accepted) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(accepted) - (AW+1)'(pop);
      if (wr_en && !accepted) overflow <= 1'b1;
    end
  end
endmodule

// File: rtl/trace_match_event_logger.sv
// trace_match_event_logger: multi-rule trace pattern matcher with trigger output and timestamped event FIFO
// Ports: trace_clk/reset clocking; trace_data/trace_valid trace word; pattern_flat,
// mask_flat, pattern_enable rule set; trig_enable/trig_toggle trigger control;
// capture_en logging enable; ts_clear zeroes timestamp and flushes log; trig_out
// trigger; fifo_rd_en/fifo_dout/fifo_empty/fifo_full/fifo_count/fifo_overflow log port.
module trace_match_event_logger
  import trace_match_pkg::*;
#(
  parameter int pDATA_WIDTH = 64,
  parameter int pRULES      = 8,
  parameter int pTS_WIDTH   = 32,
  parameter int pFIFO_DEPTH = 16
) (
  input  logic                              trace_clk,
  input  logic                              reset,
  input  logic [pDATA_WIDTH-1:0]            trace_data,
  input  logic                              trace_valid,
  input  logic [pRULES*pDATA_WIDTH-1:0]     pattern_flat,
  input  logic [pRULES*pDATA_WIDTH-1:0]     mask_flat,
  input  logic [pRULES-1:0]                 pattern_enable,
  input  logic                              trig_enable,
  input  logic                              trig_toggle,
  input  logic                              capture_en,
  input  logic                              ts_clear,
  output logic                              trig_out,
  input  logic                              fifo_rd_en,
  output logic [pRULES+pTS_WIDTH:0]         fifo_dout,
  output logic                              fifo_empty,
  output logic                              fifo_full,
  output logic [$clog2(pFIFO_DEPTH):0]      fifo_count,
  output logic                              fifo_overflow
);
  localparam int EW   = entry_width(pRULES, pTS_WIDTH);
  localparam int HL   = hits_lsb(pTS_WIDTH);
  localparam int RB   = rollover_bit(pRULES, pTS_WIDTH);
  logic [pTS_WIDTH-1:0] ts, ts1, ts2;
  logic [pRULES-1:0] hit_c, hit1, hit2;
  logic roll_pend, pulse, tog, mode, push_ok;
  logic [EW-1:0] entry;
  always_comb begin
    hit_c = '0;
    for (int i = 0; i < pRULES; i++)
      hit_c[i] = trace_valid & pattern_enable[i] &
                 ~|((trace_data ^ pattern_flat[i*pDATA_WIDTH +: pDATA_WIDTH]) &
                    mask_flat[i*pDATA_WIDTH +: pDATA_WIDTH]);
  end
  always_comb begin
    entry = '0;
    entry[TS_LSB +: pTS_WIDTH] = ts2;
    entry[HL +: pRULES] = hit2;
    entry[RB] = roll_pend;
  end
  // the mode is latched on each match so a mode switch only shows on the next match
  assign trig_out = (mode == TRIG_TOGGLE) ? tog : pulse;
  always_ff @(posedge trace_clk) begin
    if (reset) begin
      ts        <= '0;
      ts1       <= '0;
      ts2       <= '0;
      hit1      <= '0;
      hit2      <= '0;
      roll_pend <= 1'b0;
      pulse     <= 1'b0;
      tog       <= 1'b0;
      mode      <= TRIG_PULSE;
    end else begin
      ts        <= ts_clear ? '0 : ts + pTS_WIDTH'(1);
      // a wrap this cycle postdates the entry being pushed, so it must survive the push
      roll_pend <= ts_clear ? 1'b0 : (&ts) ? 1'b1 : push_ok ? 1'b0 : roll_pend;
      hit1      <= hit_c;
      ts1       <= ts;
      hit2      <= hit1;
      ts2       <= ts1;
      pulse     <= |hit1 & trig_enable;
      if (|hit1) mode <= trig_toggle;
      if (|hit1 && trig_enable && trig_toggle == TRIG_TOGGLE) tog <= ~tog;
    end
  end
  trace_event_fifo #(.pWIDTH(EW), .pDEPTH(pFIFO_DEPTH)) u_fifo (
    .trace_clk(trace_clk),
    .reset(reset),
    .flush(ts_clear),
    .wr_en(|hit2 & capture_en),
    .din(entry),
    .accepted(push_ok),
    .rd_en(fifo_rd_en),
    .dout(fifo_dout),
    .empty(fifo_empty),
    .full(fifo_full),
    .count(fifo_count),
    .overflow(fifo_overflow)
  );
endmodule

// File: tb/tb_trace_match_event_logger.sv
// tb_trace_match_event_logger: directed self-checking bench for trace_match_event_logger
module tb_trace_match_event_logger;
  localparam int DW = 64, R = 8, TW = 8, D = 4, EW = 1 + R + TW;
  logic trace_clk = 1'b0;
  logic reset = 1'b1;
  logic [DW-1:0] trace_data = '0;
  logic trace_valid = 1'b0;
  logic [R*DW-1:0] pattern_flat = '0, mask_flat = '0;
  logic [R-1:0] pattern_enable = '0;
  logic trig_enable = 1'b0, trig_toggle = 1'b0, capture_en = 1'b0, ts_clear = 1'b0;
  logic trig_out, fifo_rd_en = 1'b0, fifo_empty, fifo_full, fifo_overflow;
  logic [EW-1:0] fifo_dout;
  logic [$clog2(D):0] fifo_count;
  logic [TW-1:0] ts_m = '0;
  int tests = 0, fails = 0;
  localparam logic [63:0] MATCH = 64'h12345678_DEADBEEF;
  trace_match_event_logger #(.pDATA_WIDTH(DW), .pRULES(R), .pTS_WIDTH(TW), .pFIFO_DEPTH(D)) dut (
    .trace_clk(trace_clk), .reset(reset), .trace_data(trace_data), .trace_valid(trace_valid),
    .pattern_flat(pattern_flat), .mask_flat(mask_flat), .pattern_enable(pattern_enable),
    .trig_enable(trig_enable), .trig_toggle(trig_toggle), .capture_en(capture_en),
    .ts_clear(ts_clear), .trig_out(trig_out), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_count(fifo_count),
    .fifo_overflow(fifo_overflow)
  );
  always #5 trace_clk = ~trace_clk;
  task automatic step();
    @(negedge trace_clk);
    ts_m = ts_m + 8'd1;
  endtask
  task automatic wait_ts(input logic [TW-1:0] t);
    while (ts_m != t) step();
  endtask
  task automatic goto_ts(input logic [TW-1:0] t);
    ts_clear = 1'b1;
    step();
    ts_clear = 1'b0;
    ts_m = '0;
    wait_ts(t);
  endtask
  task automatic word(input logic [DW-1:0] d);
    trace_data = d;
    trace_valid = 1'b1;
    step();
    trace_valid = 1'b0;
  endtask
  task automatic pop();
    fifo_rd_en = 1'b1;
    step();
    fifo_rd_en = 1'b0;
  endtask
  task automatic set_rule(input int i, input logic [DW-1:0] p, input logic [DW-1:0] m);
    pattern_flat[i*DW +: DW] = p;
    mask_flat[i*DW +: DW] = m;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    tests++; if (trig_out !== 1'b0) begin fails++; $display("FAIL reset_trig got=%b exp=0", trig_out); end
    tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL reset_empty got=%b exp=1", fifo_empty); end
    tests++; if (fifo_full !== 1'b0) begin fails++; $display("FAIL reset_full got=%b exp=0", fifo_full); end
    tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    tests++; if (fifo_overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf got=%b exp=0", fifo_overflow); end
    tests++; if (fifo_dout !== 17'h0) begin fails++; $display("FAIL reset_dout got=%h exp=0", fifo_dout); end
    reset = 1'b0;
  endtask
  task automatic test_single();
    set_rule(0, 64'h00000000_DEADBEEF, 64'h00000000_FFFFFFFF);
    pattern_enable = 8'h01;
    trig_enable = 1'b1;
    trig_toggle = 1'b0;
    capture_en = 1'b1;
    goto_ts(100);
    word(MATCH);
    tests++; if (trig_out !== 1'b0) begin fails++; $display("FAIL single_trig_c1 got=%b exp=0", trig_out); end
    step();
    tests++; if (trig_out !== 1'b1) begin fails++; $display("FAIL single_trig_c2 got=%b exp=1", trig_out); end
    step();
    tests++; if (trig_out !== 1'b0) begin fails++; $display("FAIL single_trig_c3 got=%b exp=0", trig_out); end
    tests++; if (fifo_empty !== 1'b0) begin fails++; $display("FAIL single_empty got=%b exp=0", fifo_empty); end
    tests++; if (fifo_dout !== {1'b0, 8'h01, 8'd100}) begin fails++; $display("FAIL single_entry got=%h exp=%h", fifo_dout, {1'b0, 8'h01, 8'd100}); end
    pop();
    tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL single_pop_empty got=%b exp=1", fifo_empty); end
    word(64'h12345678_DEADBEEE);
    step();
    tests++; if (trig_out !== 1'b0) begin fails++; $display("FAIL single_nomatch_trig got=%b exp=0", trig_out); end
    step();
    tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL single_nomatch_empty got=%b exp=1", fifo_empty); end
  endtask
  task automatic test_multi();
    set_rule(2, 64'hAA, 64'hFF);
    set_rule(3, 64'hAB, 64'hFF);
    set_rule(5, 64'hAA, 64'h0F);
    set_rule(7, 64'h0, 64'h0);
    pattern_enable = 8'h2C;
    goto_ts(7);
    word(64'hAA);
    step();
    tests++; if (trig_out !== 1'b1) begin fails++; $display("FAIL multi_trig_c2 got=%b exp=1", trig_out); end
    step();
    tests++; if (trig_out !== 1'b0) begin fails++; $display("FAIL multi_trig_c3 got=%b exp=0", trig_out); end
    tests++; if (fifo_count !== 3'd1) begin fails++; $display("FAIL multi_count got=%0d exp=1", fifo_count); end
    tests++; if (fifo_dout !== {1'b0, 8'h24, 8'd7}) begin fails++; $display("FAIL multi_entry got=%h exp=%h", fifo_dout, {1'b0, 8'h24, 8'd7}); end
    pop();
    pattern_enable = 8'hAC;
    wait_ts(20);
    word(64'h55);
    step();
    step();
    tests++; if (fifo_dout !== {1'b0, 8'h80, 8'd20}) begin fails++; $display("FAIL multi_zero_mask got=%h exp=%h", fifo_dout, {1'b0, 8'h80, 8'd20}); end
    pop();
  endtask
  task automatic test_toggle();
    logic exp;
    pattern_enable = 8'h01;
    capture_en = 1'b0;
    trace_data = MATCH;
    goto_ts(0);
    for (int t = 0; t < 30; t++) begin
      exp = (t == 12) || (t >= 22);
      tests++; if (trig_out !== exp) begin fails++; $display("FAIL toggle_ts%0d got=%b exp=%b", t, trig_out, exp); end
      trace_valid = (t == 10) || (t == 11) || (t == 20) || (t == 25);
      trig_enable = t < 23;
      trig_toggle = 1'b1;
      step();
    end
    trace_valid = 1'b0;
    trig_enable = 1'b1;
    trig_toggle = 1'b0;
    capture_en = 1'b1;
  endtask
  task automatic test_overflow_full_pop();
    pattern_enable = 8'h01;
    trace_data = MATCH;
    goto_ts(0);
    trace_valid = 1'b1;
    repeat (6) step();
    trace_valid = 1'b0;
    wait_ts(9);
    tests++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL ovf_count got=%0d exp=4", fifo_count); end
    tests++; if (fifo_full !== 1'b1) begin fails++; $display("FAIL ovf_full got=%b exp=1", fifo_full); end
    tests++; if (fifo_overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got=%b exp=1", fifo_overflow); end
    tests++; if (fifo_dout !== {1'b0, 8'h01, 8'd0}) begin fails++; $display("FAIL ovf_head got=%h exp=%h", fifo_dout, {1'b0, 8'h01, 8'd0}); end
    word(MATCH);
    step();
    pop();
    tests++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL fullpp_count got=%0d exp=4", fifo_count); end
    tests++; if (fifo_dout !== {1'b0, 8'h01, 8'd1}) begin fails++; $display("FAIL fullpp_head got=%h exp=%h", fifo_dout, {1'b0, 8'h01, 8'd1}); end
    tests++; if (fifo_overflow !== 1'b1) begin fails++; $display("FAIL fullpp_ovf got=%b exp=1", fifo_overflow); end
    pop();
    tests++; if (fifo_dout !== {1'b0, 8'h01, 8'd2}) begin fails++; $display("FAIL pop_head got=%h exp=%h", fifo_dout, {1'b0, 8'h01, 8'd2}); end
    tests++; if (fifo_full !== 1'b0) begin fails++; $display("FAIL pop_full got=%b exp=0", fifo_full); end
    ts_clear = 1'b1;
    step();
    ts_clear = 1'b0;
    ts_m = '0;
    tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL clr_empty got=%b exp=1", fifo_empty); end
    tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL clr_count got=%0d exp=0", fifo_count); end
    tests++; if (fifo_overflow !== 1'b0) begin fails++; $display("FAIL clr_ovf got=%b exp=0", fifo_overflow); end
  endtask
  task automatic test_clear_collide();
    wait_ts(5);
    word(MATCH);
    step();
    tests++; if (trig_out !== 1'b1) begin fails++; $display("FAIL collide_trig got=%b exp=1", trig_out); end
    ts_clear = 1'b1;
    step();
    ts_clear = 1'b0;
    ts_m = '0;
    tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL collide_empty got=%b exp=1", fifo_empty); end
    step();
    tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL collide_count got=%0d exp=0", fifo_count); end
  endtask
  task automatic test_rollover();
    goto_ts(250);
    word(MATCH);
    step();
    step();
    tests++; if (fifo_dout !== {1'b0, 8'h01, 8'd250}) begin fails++; $display("FAIL roll_e0 got=%h exp=%h", fifo_dout, {1'b0, 8'h01, 8'd250}); end
    pop();
    wait_ts(3);
    word(MATCH);
    step();
    step();
    tests++; if (fifo_dout !== {1'b1, 8'h01, 8'd3}) begin fails++; $display("FAIL roll_e1 got=%h exp=%h", fifo_dout, {1'b1, 8'h01, 8'd3}); end
    pop();
    wait_ts(9);
    word(MATCH);
    step();
    step();
    tests++; if (fifo_dout !== {1'b0, 8'h01, 8'd9}) begin fails++; $display("FAIL roll_e2 got=%h exp=%h", fifo_dout, {1'b0, 8'h01, 8'd9}); end
    pop();
  endtask
  task automatic test_reset_midflight();
    goto_ts(2);
    trace_data = MATCH;
    trace_valid = 1'b1;
    step();
    step();
    trace_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    ts_m = '0;
    for (int k = 0; k < 4; k++) begin
      tests++; if (trig_out !== 1'b0) begin fails++; $display("FAIL rstmid_trig_c%0d got=%b exp=0", k, trig_out); end
      tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL rstmid_empty_c%0d got=%b exp=1", k, fifo_empty); end
      step();
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_multi();
    test_toggle();
    test_overflow_full_pop();
    test_clear_collide();
    test_rollover();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
